dram_access_ctrl: RTL and testbench

- Controller/arbiter for the single-port data RAM shared by two requesters: the pipeline MEM stage (cpu port) and the external preload/dump port (ext port).
- Sequences whole-run ownership. Before `start`, the ext port owns the RAM and preloads the data set. During RUN the CPU has priority, with bounded ext starvation. After `halt_rise`, the ext port owns the RAM again to dump the sorted result.
- Sits between the pipeline MEM stage, the loader and the data RAM inside top.

---
 rtl/dram_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_dram_access_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_access_ctrl.sv
// rtl/dram_access_ctrl.sv - data RAM arbiter/sequencer for cpu and ext ports; optional counters under DRAM_ACCESS_CNT_EN
module dram_access_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_rise,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cpu_access_cnt,
    output logic [CNT_W-1:0]  ext_access_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t            cur_state, nxt_state;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              cpu_gnt, force_ext;
    logic              cpu_pend, ext_pend;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= ST_IDLE;
            wait_cnt  <= '0;
            cpu_pend  <= 1'b0;
            ext_pend  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
            cpu_pend  <= cpu_gnt & ~cpu_we;
            ext_pend  <= ext_gnt & ~ext_we;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        wait_nxt  = '0;
        force_ext = 1'b0;
        cpu_gnt   = 1'b0;
        ext_gnt   = 1'b0;
        cpu_stall = 1'b1;
        case (cur_state)
            ST_IDLE: begin
                ext_gnt = ext_req;
                if (start) nxt_state = ST_RUN;
            end
            ST_RUN: begin
                // CPU wins unless ext has been denied MAX_WAIT cycles in a row
                force_ext = ext_req && (wait_cnt == WAIT_MAX);
                cpu_gnt   = cpu_req & ~force_ext;
                ext_gnt   = ext_req & (~cpu_req | force_ext);
                cpu_stall = cpu_req & ~cpu_gnt;
                if (ext_req && !ext_gnt)
                    wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
                if (halt_rise) nxt_state = ST_HALTED;
            end
            ST_HALTED: begin
                ext_gnt = ext_req;
            end
            default: nxt_state = ST_IDLE;
        endcase
        if (nxt_state != ST_RUN) wait_nxt = '0;
    end

    always_comb begin
        ram_en    = cpu_gnt | ext_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            ram_we    = ext_we;
            ram_addr  = ext_addr;
            ram_wdata = ext_wdata;
        end
    end

    assign cpu_rvalid = cpu_pend;
    assign ext_rvalid = ext_pend;
    assign cpu_rdata  = cpu_pend ? ram_rdata : '0;
    assign ext_rdata  = ext_pend ? ram_rdata : '0;
    assign state      = cur_state;

`ifdef DRAM_ACCESS_CNT_EN
    logic [CNT_W-1:0] cpu_cnt_q, ext_cnt_q, stall_cnt_q;

    // Frozen in HALTED so the values survive the dump phase
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_cnt_q   <= '0;
            ext_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (cur_state != ST_HALTED) begin
            if (cpu_gnt && cpu_cnt_q != '1) cpu_cnt_q <= cpu_cnt_q + 1'b1;
            if (ext_gnt && ext_cnt_q != '1) ext_cnt_q <= ext_cnt_q + 1'b1;
            if (cur_state == ST_RUN && cpu_stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign cpu_access_cnt = cpu_cnt_q;
    assign ext_access_cnt = ext_cnt_q;
    assign stall_cnt      = stall_cnt_q;
`else
    assign cpu_access_cnt = '0;
    assign ext_access_cnt = '0;
    assign stall_cnt      = '0;
`endif

endmodule

// File: tb/tb_dram_access_ctrl.sv
// tb/tb_dram_access_ctrl.sv - directed self-checking bench for dram_access_ctrl
module tb_dram_access_ctrl;
    localparam int ADDR_W = 10, DATA_W = 32, MAX_WAIT = 8, CNT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, halt_rise;
    logic              cpu_req, cpu_we, cpu_stall, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              ext_req, ext_we, ext_gnt, ext_rvalid;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata, ext_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cpu_access_cnt, ext_access_cnt, stall_cnt;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    dram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_rise(halt_rise),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .state(state),
        .cpu_access_cnt(cpu_access_cnt), .ext_access_cnt(ext_access_cnt), .stall_cnt(stall_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 0; halt_rise = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    endtask

    initial begin
        logic fexp, crv, erv;
        reset = 0;
        idle_in();
        tick(); tick();
        #2;
        check("rst_state", state, 2'b00);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_ext_rvalid", ext_rvalid, 0);
        check("rst_idle_stall", cpu_stall, 1);
        check("rst_cpu_cnt", cpu_access_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        tick();
        reset = 1;

        // Preload with the CPU knocking: it must stay stalled
        for (int i = 0; i < 50; i++) begin
            ext_req = 1; ext_we = 1; ext_addr = ADDR_W'(i); ext_wdata = 32'h100 + i;
            cpu_req = 1; cpu_we = 1; cpu_addr = 10'd999; cpu_wdata = 32'hdead;
            #2;
            check("pre_ext_gnt", ext_gnt, 1);
            check("pre_cpu_stall", cpu_stall, 1);
            check("pre_state", state, 2'b00);
            check("pre_ram_addr", ram_addr, i);
            check("pre_ram_wdata", ram_wdata, 32'h100 + i);
            tick();
        end
        idle_in();
        #2;
        check("pre_no_rvalid", ext_rvalid, 0);
        tick();

        start = 1;
        #2;
        check("start_cycle_state", state, 2'b00);
        tick();
        start = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 10'd5;
        #2;
        check("run_state", state, 2'b01);
        check("run_cpu_stall", cpu_stall, 0);
        check("run_ram_addr", ram_addr, 5);
        tick();
        idle_in();
        #2;
        check("rd5_rvalid", cpu_rvalid, 1);
        check("rd5_rdata", cpu_rdata, 32'h105);
        check("rd5_ext_rvalid", ext_rvalid, 0);
        tick();

        // Both requesting: ext forced through every 9th cycle
        for (int k = 0; k < 18; k++) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 10'd0;
            ext_req = 1; ext_we = 0; ext_addr = 10'd10;
            #2;
            fexp = (k % 9 == 8);
            crv  = (k > 0) && ((k - 1) % 9 != 8);
            erv  = (k > 0) && ((k - 1) % 9 == 8);
            check("starve_ext_gnt", ext_gnt, fexp);
            check("starve_cpu_stall", cpu_stall, fexp);
            check("starve_cpu_rvalid", cpu_rvalid, crv);
            check("starve_cpu_rdata", cpu_rdata, crv ? 32'h100 : 32'h0);
            check("starve_ext_rvalid", ext_rvalid, erv);
            check("starve_ext_rdata", ext_rdata, erv ? 32'h10a : 32'h0);
`ifdef DRAM_ACCESS_CNT_EN
            if (k == 9) check("starve_stall_cnt9", stall_cnt, 1);
`endif
            tick();
        end

        // CPU read in the halt_rise cycle still completes
        idle_in();
        cpu_req = 1; cpu_addr = 10'd7; halt_rise = 1;
        #2;
        check("halt_cycle_state", state, 2'b01);
        check("halt_cycle_stall", cpu_stall, 0);
        check("halt_cycle_ext_rvalid", ext_rvalid, 1);
        check("halt_cycle_ext_rdata", ext_rdata, 32'h10a);
        tick();

        halt_rise = 0; cpu_req = 1;
        ext_req = 1; ext_we = 0; ext_addr = 10'd0;
        #2;
        check("halted_state", state, 2'b10);
        check("halt_rd_rvalid", cpu_rvalid, 1);
        check("halt_rd_rdata", cpu_rdata, 32'h107);
        check("halted_stall", cpu_stall, 1);
        check("dump_gnt0", ext_gnt, 1);
`ifdef DRAM_ACCESS_CNT_EN
        check("cnt_cpu", cpu_access_cnt, 18);
        check("cnt_ext", ext_access_cnt, 52);
        check("cnt_stall", stall_cnt, 2);
`else
        check("cnt_cpu_off", cpu_access_cnt, 0);
        check("cnt_ext_off", ext_access_cnt, 0);
        check("cnt_stall_off", stall_cnt, 0);
`endif
        tick();
        for (int i = 1; i < 50; i++) begin
            ext_addr = ADDR_W'(i);
            #2;
            check("dump_gnt", ext_gnt, 1);
            check("dump_rvalid", ext_rvalid, 1);
            check("dump_rdata", ext_rdata, 32'h100 + i - 1);
            tick();
        end
        idle_in();
        #2;
        check("dump_last_rvalid", ext_rvalid, 1);
        check("dump_last_rdata", ext_rdata, 32'h131);
`ifdef DRAM_ACCESS_CNT_EN
        check("cnt_ext_hold", ext_access_cnt, 52);
`endif
        tick();

        halt_rise = 1;
        #2;
        tick();
        halt_rise = 0; start = 1;
        #2;
        check("halted_halt_ignored", state, 2'b10);
        tick();
        start = 0;
        #2;
        check("halted_start_ignored", state, 2'b10);
        tick();

        reset = 0;
        #2;
        tick();
        reset = 1;
        #2;
        check("rst2_state", state, 2'b00);
        start = 1; halt_rise = 1;
        #2;
        tick();
        idle_in();
        #2;
        check("start_halt_same", state, 2'b01);
        tick();

        // Reset lands on the edge that would return the read
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'd3; reset = 0;
        #2;
        check("rst_rd_gnt", cpu_stall, 0);
        tick();
        idle_in();
        #2;
        check("rst_rd_rvalid", cpu_rvalid, 0);
        check("rst_rd_state", state, 2'b00);
        check("rst_rd_cpu_cnt", cpu_access_cnt, 0);
        check("rst_rd_ext_cnt", ext_access_cnt, 0);
        check("rst_rd_stall_cnt", stall_cnt, 0);
        reset = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
